// File: rtl/map_reduce_pkg.sv
// Shared types and helpers for the keyed map-reduce engine: FSM states,
// lane/tree geometry and the saturating adder used by mappers and tree nodes.
package map_reduce_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_REDUCE,
        ST_DONE
    } state_e;

    // Internal width of the saturating adder; CNT_WIDTH must not exceed it.
    localparam int SAT_W = 64;

    function automatic int lanes(input int data_width, input int key_width);
        return data_width / key_width;
    endfunction

    function automatic int tree_depth(input int num_mappers);
        return (num_mappers <= 1) ? 1 : $clog2(num_mappers);
    endfunction

    function automatic logic [SAT_W-1:0] sat_add(
        input logic [SAT_W-1:0] a,
        input logic [SAT_W-1:0] b,
        input int               width
    );
        logic [SAT_W:0] sum;
        logic [SAT_W:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = ((SAT_W + 1)'(1) << width) - (SAT_W + 1)'(1);
        if (sum > lim) begin
            return lim[SAT_W-1:0];
        end
        return sum[SAT_W-1:0];
    endfunction

endpackage

// File: rtl/map_reduce_engine_map_lane_counter.sv
// One mapper: counts key-matching lanes of an accepted word, stays busy for
// MAP_LAT cycles and folds the lane count into a saturating accumulator.
module map_lane_counter
    import map_reduce_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int KEY_WIDTH  = 8,
    parameter int CNT_WIDTH  = 32,
    parameter int MAP_LAT    = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clr_i,
    input  logic                  accept_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic [KEY_WIDTH-1:0]  key_i,
    output logic                  rdy_o,
    output logic                  idle_o,
    output logic [CNT_WIDTH-1:0]  count_o
);

    localparam int LANES = lanes(DATA_WIDTH, KEY_WIDTH);
    localparam int LC_W  = $clog2(LANES + 1);
    localparam int REM_W = (MAP_LAT > 1) ? $clog2(MAP_LAT) : 1;

    logic [LANES-1:0]     lane_hit;
    logic [LC_W-1:0]      hit_cnt;
    logic [REM_W-1:0]     rem_q, rem_d;
    logic [LC_W-1:0]      pend_q, pend_d;
    logic [CNT_WIDTH-1:0] acc_q, acc_d;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign lane_hit[gi] = (data_i[gi*KEY_WIDTH +: KEY_WIDTH] == key_i);
        end
    endgenerate

    always_comb begin
        hit_cnt = '0;
        for (int i = 0; i < LANES; i++) begin
            hit_cnt = hit_cnt + LC_W'(lane_hit[i]);
        end
    end

    // rem_q counts the busy cycles still to come after the accept cycle;
    // the lane count lands in the accumulator on the last busy cycle.
    always_comb begin
        rem_d  = rem_q;
        pend_d = pend_q;
        acc_d  = acc_q;
        if (clr_i) begin
            rem_d  = '0;
            pend_d = '0;
            acc_d  = '0;
        end else if (accept_i) begin
            if (MAP_LAT == 1) begin
                acc_d = CNT_WIDTH'(sat_add(SAT_W'(acc_q), SAT_W'(hit_cnt), CNT_WIDTH));
            end else begin
                rem_d  = REM_W'(MAP_LAT - 1);
                pend_d = hit_cnt;
            end
        end else if (rem_q == REM_W'(1)) begin
            acc_d = CNT_WIDTH'(sat_add(SAT_W'(acc_q), SAT_W'(pend_q), CNT_WIDTH));
            rem_d = '0;
        end else if (rem_q != '0) begin
            rem_d = rem_q - REM_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rem_q  <= '0;
            pend_q <= '0;
            acc_q  <= '0;
        end else begin
            rem_q  <= rem_d;
            pend_q <= pend_d;
            acc_q  <= acc_d;
        end
    end

    assign rdy_o   = (rem_q == '0);
    // Idle means the count will be final at the next clock edge.
    assign idle_o  = (rem_q <= REM_W'(1));
    assign count_o = acc_q;

endmodule

// File: rtl/map_reduce_engine.sv
// Keyed map-reduce engine: round-robin dispatch of stream words to lane-counting
// mappers, then a pipelined saturating adder tree reduces the per-mapper counts.
module map_reduce_engine
    import map_reduce_pkg::*;
#(
    parameter int NUM_MAPPERS = 16,
    parameter int DATA_WIDTH  = 64,
    parameter int KEY_WIDTH   = 8,
    parameter int CNT_WIDTH   = 32,
    parameter int MAP_LAT     = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic [KEY_WIDTH-1:0]  i_key,
    input  logic [DATA_WIDTH-1:0] i_strm_data,
    input  logic                  i_strm_data_valid,
    output logic                  o_strm_data_rdy,
    input  logic                  i_flush,
    output logic [CNT_WIDTH-1:0]  o_data_count,
    output logic                  o_count_valid,
    output logic                  o_busy
);

    localparam int L     = tree_depth(NUM_MAPPERS);
    localparam int P     = 1 << L;
    localparam int PTR_W = (NUM_MAPPERS > 1) ? $clog2(NUM_MAPPERS) : 1;
    localparam int RED_W = $clog2(L) + 1;

    state_e                 state_q, state_d;
    logic [KEY_WIDTH-1:0]   key_q;
    logic [PTR_W-1:0]       ptr_q, ptr_d;
    logic [RED_W-1:0]       red_q, red_d;
    logic                   start_ok;
    logic                   beat;
    logic                   all_idle;
    logic [NUM_MAPPERS-1:0] map_rdy;
    logic [NUM_MAPPERS-1:0] map_idle;
    logic [NUM_MAPPERS-1:0] map_accept;
    logic [(1<<PTR_W)-1:0]  rdy_pad;
    logic [CNT_WIDTH-1:0]   map_cnt [NUM_MAPPERS];
    logic [CNT_WIDTH-1:0]   leaf    [P];
    logic [CNT_WIDTH-1:0]   tree_q  [1:P-1];
    logic [CNT_WIDTH-1:0]   tree_d  [1:P-1];

    assign start_ok = i_start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign beat     = (state_q == ST_RUN) && i_strm_data_valid && rdy_pad[ptr_q];
    assign all_idle = &map_idle;

    genvar gi;
    generate
        for (gi = 0; gi < (1 << PTR_W); gi++) begin : g_rdy
            if (gi < NUM_MAPPERS) begin : g_real
                assign rdy_pad[gi] = map_rdy[gi];
            end else begin : g_pad
                assign rdy_pad[gi] = 1'b0;
            end
        end

        for (gi = 0; gi < NUM_MAPPERS; gi++) begin : g_map
            assign map_accept[gi] = beat && (ptr_q == PTR_W'(gi));
            map_lane_counter #(
                .DATA_WIDTH(DATA_WIDTH),
                .KEY_WIDTH (KEY_WIDTH),
                .CNT_WIDTH (CNT_WIDTH),
                .MAP_LAT   (MAP_LAT)
            ) u_map (
                .clk_i   (i_clk),
                .rst_ni  (i_rst_n),
                .clr_i   (start_ok),
                .accept_i(map_accept[gi]),
                .data_i  (i_strm_data),
                .key_i   (key_q),
                .rdy_o   (map_rdy[gi]),
                .idle_o  (map_idle[gi]),
                .count_o (map_cnt[gi])
            );
        end

        for (gi = 0; gi < P; gi++) begin : g_leaf
            if (gi < NUM_MAPPERS) begin : g_real
                assign leaf[gi] = map_cnt[gi];
            end else begin : g_pad
                assign leaf[gi] = '0;
            end
        end

        // Heap-indexed tree: node n adds children 2n and 2n+1; indices >= P are leaves.
        for (gi = 1; gi < P; gi++) begin : g_node
            if (2 * gi >= P) begin : g_bottom
                assign tree_d[gi] = CNT_WIDTH'(sat_add(SAT_W'(leaf[2*gi-P]),
                                                       SAT_W'(leaf[2*gi+1-P]), CNT_WIDTH));
            end else begin : g_inner
                assign tree_d[gi] = CNT_WIDTH'(sat_add(SAT_W'(tree_q[2*gi]),
                                                       SAT_W'(tree_q[2*gi+1]), CNT_WIDTH));
            end
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: if (i_start)     state_d = ST_RUN;
            ST_RUN:           if (i_flush)     state_d = ST_DRAIN;
            ST_DRAIN:         if (all_idle)    state_d = ST_REDUCE;
            ST_REDUCE:        if (red_q == RED_W'(L - 1)) state_d = ST_DONE;
            default:          state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        o_strm_data_rdy = 1'b0;
        o_busy          = 1'b0;
        o_count_valid   = 1'b0;
        case (state_q)
            ST_RUN: begin
                o_strm_data_rdy = rdy_pad[ptr_q];
                o_busy          = 1'b1;
            end
            ST_DRAIN, ST_REDUCE: o_busy = 1'b1;
            ST_DONE:             o_count_valid = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        ptr_d = ptr_q;
        if (beat) begin
            ptr_d = (ptr_q == PTR_W'(NUM_MAPPERS - 1)) ? '0 : ptr_q + PTR_W'(1);
        end
        red_d = (state_q == ST_REDUCE) ? red_q + RED_W'(1) : '0;
    end

    // Tree registers only advance in REDUCE, so the root holds the result in DONE.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            key_q <= '0;
            ptr_q <= '0;
            red_q <= '0;
            for (int i = 1; i < P; i++) begin
                tree_q[i] <= '0;
            end
        end else begin
            ptr_q <= ptr_d;
            red_q <= red_d;
            if (start_ok) begin
                key_q <= i_key;
            end
            for (int i = 1; i < P; i++) begin
                if (start_ok) begin
                    tree_q[i] <= '0;
                end else if (state_q == ST_REDUCE) begin
                    tree_q[i] <= tree_d[i];
                end
            end
        end
    end

    assign o_data_count = tree_q[1];

endmodule

// File: tb/tb_map_reduce_engine.sv
// Bench for map_reduce_engine: five parameterisations side by side, directed
// scenarios plus randomized jobs checked against a lane-counting reference model.
module tb_map_reduce_engine;

    localparam int N = 5;
    localparam int NM  [N] = '{4, 2, 4, 1, 16};
    localparam int ML  [N] = '{2, 4, 2, 1, 2};
    localparam int CWS [N] = '{32, 32, 4, 32, 32};
    localparam int LV  [N] = '{2, 1, 2, 1, 4};

    typedef struct {
        logic [31:0] cnt;
        int          lat;
        int          stalls;
        bit          tmo;
        logic        s_valid;
        logic        s_busy;
        logic [31:0] s_cnt;
        logic        e_busy;
    } job_res_t;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  start_v = '0;
    logic [7:0]    key_i = '0;
    logic [63:0]   data  = '0;
    logic          valid = 1'b0;
    logic          flush = 1'b0;
    wire  [N-1:0]  rdy_v;
    wire  [N-1:0]  valid_v;
    wire  [N-1:0]  busy_v;
    wire  [31:0]   cnt_v [N];
    int            cyc = 0;
    int            checks = 0;
    int            failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_dut
            logic [CWS[gi]-1:0] cnt;
            map_reduce_engine #(
                .NUM_MAPPERS(NM[gi]),
                .DATA_WIDTH (64),
                .KEY_WIDTH  (8),
                .CNT_WIDTH  (CWS[gi]),
                .MAP_LAT    (ML[gi])
            ) dut (
                .i_clk            (clk),
                .i_rst_n          (rst_n),
                .i_start          (start_v[gi]),
                .i_key            (key_i),
                .i_strm_data      (data),
                .i_strm_data_valid(valid),
                .o_strm_data_rdy  (rdy_v[gi]),
                .i_flush          (flush),
                .o_data_count     (cnt),
                .o_count_valid    (valid_v[gi]),
                .o_busy           (busy_v[gi])
            );
            assign cnt_v[gi] = 32'(cnt);
        end
    endgenerate

    // Reference: count matching bytes over the whole job, clip to the count range.
    function automatic logic [31:0] model(input int idx, input logic [7:0] key,
                                          input logic [63:0] words[$]);
        longint total = 0;
        longint lim;
        logic [63:0] w;
        foreach (words[j]) begin
            w = words[j];
            for (int b = 0; b < 8; b++) begin
                if (w[b*8 +: 8] == key) total++;
            end
        end
        lim = (longint'(1) << CWS[idx]) - 1;
        return 32'((total > lim) ? lim : total);
    endfunction

    function automatic logic [63:0] rand_word(input logic [7:0] key);
        logic [63:0] w;
        for (int b = 0; b < 8; b++) begin
            w[b*8 +: 8] = ($urandom_range(0, 1) != 0) ? key : 8'($urandom);
        end
        return w;
    endfunction

    task automatic run_job(input int idx, input logic [7:0] key, input logic [63:0] words[$],
                           input bit gaps, input int inj, output job_res_t r);
        int i = 0;
        int f = 0;
        int guard = 0;
        int n = words.size();
        r.cnt = '0; r.lat = -1; r.stalls = 0; r.tmo = 1'b0;
        r.s_valid = 1'b0; r.s_busy = 1'b0; r.s_cnt = '0; r.e_busy = 1'b0;
        @(negedge clk);
        key_i = key;
        start_v[idx] = 1'b1;
        @(negedge clk);
        start_v[idx] = 1'b0;
        r.s_valid = valid_v[idx];
        r.s_busy  = busy_v[idx];
        r.s_cnt   = cnt_v[idx];
        while (i < n && guard < 2000) begin
            valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            data  = words[i];
            if (i == inj) begin
                start_v[idx] = 1'b1;
                key_i = ~key;
            end else begin
                start_v[idx] = 1'b0;
                key_i = key;
            end
            flush = valid && rdy_v[idx] && (i == n - 1);
            if (valid && !rdy_v[idx]) r.stalls++;
            if (valid && rdy_v[idx]) begin
                if (i == n - 1) f = cyc;
                i++;
            end
            guard++;
            @(negedge clk);
        end
        valid = 1'b0;
        flush = 1'b0;
        start_v[idx] = 1'b0;
        key_i = key;
        if (i < n) r.tmo = 1'b1;
        guard = 0;
        while (!valid_v[idx] && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!valid_v[idx]) r.tmo = 1'b1;
        r.lat    = cyc - f;
        r.cnt    = cnt_v[idx];
        r.e_busy = busy_v[idx];
        $display("job inst=%0d key=%h words=%0d count=%0d lat=%0d stalls=%0d timeout=%0d",
                 idx, key, n, r.cnt, r.lat, r.stalls, r.tmo);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < N; i++) begin
            checks++;
            if ({rdy_v[i], valid_v[i], busy_v[i]} !== 3'b000 || cnt_v[i] !== 32'd0) begin
                failures++;
                $display("FAIL reset inst=%0d rdy=%b valid=%b busy=%b count=%0d, expected all 0",
                         i, rdy_v[i], valid_v[i], busy_v[i], cnt_v[i]);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_all_match();
        logic [63:0] w[$];
        job_res_t r;
        repeat (8) w.push_back(64'h4141414141414141);
        run_job(0, 8'h41, w, 1'b0, -1, r);
        checks++;
        if (r.tmo || r.cnt !== 32'd64) begin
            failures++;
            $display("FAIL all_match_count got=%0d timeout=%0d expected=64", r.cnt, r.tmo);
        end
        checks++;
        if (r.lat !== LV[0] + 2) begin
            failures++;
            $display("FAIL all_match_latency got=%0d expected=%0d", r.lat, LV[0] + 2);
        end
        checks++;
        if (r.stalls !== 0) begin
            failures++;
            $display("FAIL all_match_stalls got=%0d expected=0", r.stalls);
        end
        checks++;
        if (r.s_busy !== 1'b1 || r.e_busy !== 1'b0) begin
            failures++;
            $display("FAIL all_match_busy run=%b done=%b expected run=1 done=0", r.s_busy, r.e_busy);
        end
    endtask

    task automatic test_restart();
        logic [63:0] w[$];
        job_res_t r;
        repeat (3) w.push_back(64'h4100410041004100);
        repeat (5) w.push_back(64'h0);
        run_job(0, 8'h41, w, 1'b0, -1, r);
        checks++;
        if (r.tmo || r.cnt !== 32'd12) begin
            failures++;
            $display("FAIL sparse_count got=%0d timeout=%0d expected=12", r.cnt, r.tmo);
        end
        run_job(0, 8'h00, w, 1'b0, -1, r);
        checks++;
        if (r.s_valid !== 1'b0 || r.s_cnt !== 32'd0) begin
            failures++;
            $display("FAIL restart_clear valid=%b count=%0d expected valid=0 count=0",
                     r.s_valid, r.s_cnt);
        end
        checks++;
        if (r.tmo || r.cnt !== 32'd52) begin
            failures++;
            $display("FAIL zero_key_count got=%0d timeout=%0d expected=52", r.cnt, r.tmo);
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] w[$];
        job_res_t r;
        logic [31:0] exp;
        repeat (10) w.push_back(rand_word(8'h41));
        exp = model(1, 8'h41, w);
        run_job(1, 8'h41, w, 1'b0, -1, r);
        checks++;
        if (r.tmo || r.cnt !== exp) begin
            failures++;
            $display("FAIL backpressure_count got=%0d timeout=%0d expected=%0d", r.cnt, r.tmo, exp);
        end
        checks++;
        if (r.stalls !== 8) begin
            failures++;
            $display("FAIL backpressure_stalls got=%0d expected=8", r.stalls);
        end
    endtask

    task automatic test_saturation();
        logic [63:0] w[$];
        job_res_t r;
        repeat (4) w.push_back(64'h4141414141414141);
        run_job(2, 8'h41, w, 1'b0, -1, r);
        checks++;
        if (r.tmo || r.cnt !== 32'd15) begin
            failures++;
            $display("FAIL saturation_count got=%0d timeout=%0d expected=15", r.cnt, r.tmo);
        end
    endtask

    task automatic test_async_reset();
        logic [63:0] w[$];
        job_res_t r;
        @(negedge clk);
        key_i = 8'h41;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        valid = 1'b1;
        data  = 64'h4141414141414141;
        repeat (3) @(negedge clk);
        valid = 1'b0;
        checks++;
        if (busy_v[0] !== 1'b1) begin
            failures++;
            $display("FAIL midrun_busy got=%b expected=1", busy_v[0]);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({rdy_v[0], valid_v[0], busy_v[0]} !== 3'b000 || cnt_v[0] !== 32'd0) begin
            failures++;
            $display("FAIL async_reset rdy=%b valid=%b busy=%b count=%0d expected all 0",
                     rdy_v[0], valid_v[0], busy_v[0], cnt_v[0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        w.push_back(64'h4141414141414141);
        run_job(0, 8'h41, w, 1'b0, -1, r);
        checks++;
        if (r.tmo || r.cnt !== 32'd8) begin
            failures++;
            $display("FAIL post_reset_count got=%0d timeout=%0d expected=8", r.cnt, r.tmo);
        end
    endtask

    task automatic test_ignored();
        logic [63:0] w[$];
        job_res_t r;
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++;
        if (busy_v[3] !== 1'b0 || valid_v[3] !== 1'b0) begin
            failures++;
            $display("FAIL idle_flush busy=%b valid=%b expected busy=0 valid=0",
                     busy_v[3], valid_v[3]);
        end
        repeat (2) w.push_back(64'h4141414141414141);
        run_job(3, 8'h41, w, 1'b0, 1, r);
        checks++;
        if (r.tmo || r.cnt !== 32'd16) begin
            failures++;
            $display("FAIL run_start_count got=%0d timeout=%0d expected=16", r.cnt, r.tmo);
        end
        checks++;
        if (r.lat !== LV[3] + 2) begin
            failures++;
            $display("FAIL single_mapper_latency got=%0d expected=%0d", r.lat, LV[3] + 2);
        end
    endtask

    task automatic test_random();
        logic [63:0] w[$];
        job_res_t r;
        logic [7:0] key;
        logic [31:0] exp;
        int n;
        for (int idx = 0; idx < N; idx++) begin
            for (int j = 0; j < 3; j++) begin
                w = {};
                key = 8'($urandom);
                n = $urandom_range(1, 12);
                for (int k = 0; k < n; k++) w.push_back(rand_word(key));
                exp = model(idx, key, w);
                run_job(idx, key, w, 1'b1, -1, r);
                checks++;
                if (r.tmo || r.cnt !== exp) begin
                    failures++;
                    $display("FAIL random_count inst=%0d job=%0d got=%0d timeout=%0d expected=%0d",
                             idx, j, r.cnt, r.tmo, exp);
                end
                if (ML[idx] <= 2) begin
                    checks++;
                    if (r.lat !== LV[idx] + 2) begin
                        failures++;
                        $display("FAIL random_latency inst=%0d job=%0d got=%0d expected=%0d",
                                 idx, j, r.lat, LV[idx] + 2);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_all_match();
        test_restart();
        test_backpressure();
        test_saturation();
        test_async_reset();
        test_ignored();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/map_reduce_engine.md
# map_reduce_engine

Parametrised keyed map-reduce accelerator for the PCIe user-logic stream path. Incoming DATA_WIDTH-bit stream words are dispatched round-robin to NUM_MAPPERS lane-counting mappers; each mapper counts KEY_WIDTH-bit lanes equal to a per-job key. On a flush, a pipelined saturating adder tree reduces all per-mapper counts to one job result. Jobs are framed by start/flush, results are held with a valid flag, and multi-cycle mappers apply backpressure.

## Interface
- NUM_MAPPERS, 16, mapper count (≥1, any integer)
- DATA_WIDTH, 64, stream word width
- KEY_WIDTH, 8, lane/key width; DATA_WIDTH must be a multiple of it
- CNT_WIDTH, 32, width of every count and of the result
- MAP_LAT, 2, cycles a mapper is busy per accepted word (≥1)
- i_clk  in  1  sole clock, rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_start  in  1  pulse: latch i_key, zero counts, begin job
- i_key  in  KEY_WIDTH  lane value to count, sampled with i_start
- i_strm_data  in  DATA_WIDTH  stream word
- i_strm_data_valid  in  1  word valid
- o_strm_data_rdy  out  1  engine accepts word this cycle
- i_flush  in  1  pulse: end of job input
- o_data_count  out  CNT_WIDTH  job result, stable while o_count_valid
- o_count_valid  out  1  result valid
- o_busy  out  1  high in RUN, DRAIN, REDUCE

## Operation
- States: IDLE, RUN, DRAIN, REDUCE, DONE.
- IDLE/DONE + i_start → RUN next cycle; key latched, all mapper counts, tree registers and o_data_count zeroed, o_count_valid cleared. i_flush in the same cycle is ignored.
- RUN: o_strm_data_rdy = mapper_rdy[ptr]. Beat = valid && rdy; word goes to mapper[ptr], ptr ← (ptr+1) mod NUM_MAPPERS. i_flush → DRAIN; a beat in the flush cycle is counted.
- DRAIN: rdy low; exit to REDUCE in the first cycle all mappers are idle.
- REDUCE: adder tree of L = max(1, ceil(log2 NUM_MAPPERS)) registered stages; counter runs L cycles → DONE.
- DONE: o_data_count = tree output, o_count_valid = 1 until next i_start.
- i_start in RUN/DRAIN/REDUCE and i_flush outside RUN: ignored.
- Mapper: on accept, count lanes equal to key (0..DATA_WIDTH/KEY_WIDTH), busy for MAP_LAT cycles, add to its count on the last busy cycle, rdy again next cycle.
- All additions (mapper accumulate, every tree node) saturate at 2^CNT_WIDTH−1; no wrap.
- ptr is not reset by i_start; dispatch order across jobs is irrelevant to the result.

## Timing
- Reset: state IDLE, ptr 0, counts 0, o_strm_data_rdy 0, o_data_count 0, o_count_valid 0, o_busy 0; asserts asynchronously at any point, including mid-job.
- i_start at cycle s → RUN at s+1, rdy can be high at s+1.
- Word accepted at t contributes to its mapper count at t+MAP_LAT−1; mapper rdy high at t+MAP_LAT.
- Full throughput (rdy always high in RUN) iff NUM_MAPPERS ≥ MAP_LAT.
- i_flush at f with mappers idle by f+1: DRAIN at f+1, REDUCE f+2..f+1+L, o_count_valid high from f+2+L.

## Structure
- Package map_reduce_pkg: state enum, LANES = DATA_WIDTH/KEY_WIDTH, saturating-add function, tree-depth function.
- Sub-module map_lane_counter: one mapper (lane compare, popcount, busy counter, saturating accumulator), instantiated NUM_MAPPERS times; dispatcher FSM and tree stay in the top.

## Test plan
- NUM_MAPPERS=4, MAP_LAT=2, key 0x41, 8 words 0x4141414141414141, flush with last beat → o_data_count 64, valid at f+4, rdy never low in RUN.
- Same, words 0x4100410041004100 ×3 then 0x0 ×5 → 12; second job with key 0x00 over same data → 52 (old result cleared on start).
- NUM_MAPPERS=2, MAP_LAT=4, valid held high for 10 words → rdy 2-of-4 duty, all 10 words counted, no beat lost or doubled.
- CNT_WIDTH=4, key 0x41, 4 all-match words → 15 (saturated), not 0.
- i_rst_n low mid-RUN after 3 words → all outputs 0 immediately; after release, new job with 1 all-match word → 8.
- NUM_MAPPERS=1, MAP_LAT=1, flush in IDLE and start in RUN ignored; normal job with 2 all-match words → 16, L=1.
